// File: rtl/mac_pkg.sv
// Shared constants for the MAC bank and its sequencer: lane geometry, datapath widths,
// and the sequencer state encoding.
package mac_pkg;

   localparam int LANES        = 8;
   localparam int PIPE_LAT_DEF = 4;
   localparam int DATA_W       = 8;
   localparam int ACC_W        = 24;
   localparam int OUT_W        = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } seqState_t;

endpackage

// File: rtl/mac_bank_seq_if.sv
// Control/buffer bus between the MAC-bank sequencer (master) and its environment (slave).
interface mac_bank_seq_if #(
   parameter int GRP_W  = 6,
   parameter int CO_W   = 8,
   parameter int PIX_W  = 12,
   parameter int ADDR_W = 16
);
   logic              start_i;
   logic [GRP_W-1:0]  cfg_grp_i;
   logic [CO_W-1:0]   cfg_co_i;
   logic [PIX_W-1:0]  cfg_pix_i;
   logic              busy_o;
   logic              done_o;
   logic              din_rd_o;
   logic [ADDR_W-1:0] din_addr_o;
   logic              wgt_rd_o;
   logic [ADDR_W-1:0] wgt_addr_o;
   logic              mac_vld_o;
   logic              mac_first_o;
   logic              mac_last_o;
   logic              out_vld_o;
   logic              out_rdy_i;
   logic [ADDR_W-1:0] out_addr_o;

   modport master (
      input  start_i, cfg_grp_i, cfg_co_i, cfg_pix_i, out_rdy_i,
      output busy_o, done_o, din_rd_o, din_addr_o, wgt_rd_o, wgt_addr_o,
             mac_vld_o, mac_first_o, mac_last_o, out_vld_o, out_addr_o
   );

   modport slave (
      output start_i, cfg_grp_i, cfg_co_i, cfg_pix_i, out_rdy_i,
      input  busy_o, done_o, din_rd_o, din_addr_o, wgt_rd_o, wgt_addr_o,
             mac_vld_o, mac_first_o, mac_last_o, out_vld_o, out_addr_o
   );
endinterface

// File: rtl/mac_loop_cnt.sv
// Nested grp/co/pix wrap counters with running address bases, so buffer addresses
// are formed by addition only.
module mac_loop_cnt #(
   parameter int GRP_W  = 6,
   parameter int CO_W   = 8,
   parameter int PIX_W  = 12,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load,
   input  logic [GRP_W-1:0]  cfgGrp,
   input  logic [CO_W-1:0]   cfgCo,
   input  logic [PIX_W-1:0]  cfgPix,
   input  logic              stepGrp,
   input  logic              stepOut,
   output logic              grpFirst,
   output logic              grpLast,
   output logic              lastOut,
   output logic [ADDR_W-1:0] dinAddr,
   output logic [ADDR_W-1:0] wgtAddr,
   output logic [ADDR_W-1:0] outAddr
);

   logic [GRP_W-1:0]  grpNReg, grpReg;
   logic [CO_W-1:0]   coNReg, coReg;
   logic [PIX_W-1:0]  pixNReg, pixReg;
   logic [ADDR_W-1:0] dinBaseReg, wgtBaseReg, outAddrReg;
   logic [ADDR_W-1:0] grpStep;
   logic              coLast, pixLast;

   assign grpStep  = ADDR_W'(grpNReg);
   assign grpFirst = (grpReg == '0);
   assign grpLast  = (grpReg == grpNReg - GRP_W'(1));
   assign coLast   = (coReg == coNReg - CO_W'(1));
   assign pixLast  = (pixReg == pixNReg - PIX_W'(1));
   assign lastOut  = coLast & pixLast;

   assign dinAddr = dinBaseReg + ADDR_W'(grpReg);
   assign wgtAddr = wgtBaseReg + ADDR_W'(grpReg);
   assign outAddr = outAddrReg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         grpNReg    <= '0;
         coNReg     <= '0;
         pixNReg    <= '0;
         grpReg     <= '0;
         coReg      <= '0;
         pixReg     <= '0;
         dinBaseReg <= '0;
         wgtBaseReg <= '0;
         outAddrReg <= '0;
      end else if (load) begin
         grpNReg    <= cfgGrp;
         coNReg     <= cfgCo;
         pixNReg    <= cfgPix;
         grpReg     <= '0;
         coReg      <= '0;
         pixReg     <= '0;
         dinBaseReg <= '0;
         wgtBaseReg <= '0;
         outAddrReg <= '0;
      end else begin
         if (stepGrp) begin
            grpReg <= grpLast ? '0 : grpReg + 1'b1;
         end
         // Filter is the inner loop: its weight base restarts for every new pixel.
         if (stepOut) begin
            outAddrReg <= outAddrReg + 1'b1;
            if (coLast) begin
               coReg      <= '0;
               wgtBaseReg <= '0;
               pixReg     <= pixReg + 1'b1;
               dinBaseReg <= dinBaseReg + grpStep;
            end else begin
               coReg      <= coReg + 1'b1;
               wgtBaseReg <= wgtBaseReg + grpStep;
            end
         end
      end
   end

endmodule

// File: rtl/mac_bank_seq.sv
// Sequencer for the 8-lane MAC bank: issues buffer reads per output, waits out the
// MAC + adder-tree pipeline, then hands each result to the output buffer.
module mac_bank_seq
   import mac_pkg::*;
#(
   parameter int PIPE_LAT = PIPE_LAT_DEF,
   parameter int GRP_W    = 6,
   parameter int CO_W     = 8,
   parameter int PIX_W    = 12,
   parameter int ADDR_W   = 16
) (
   input logic           clk,
   input logic           rstn,
   mac_bank_seq_if.master bus
);

   localparam int DR_W = $clog2(PIPE_LAT + 1) + 1;

   seqState_t         stateReg, stateNext;
   logic [DR_W-1:0]   drainCntReg;
   logic              macVldReg, macFirstReg, macLastReg, doneReg;
   logic              load, stepGrp, stepOut, issueRd, cfgZero;
   logic              grpFirst, grpLast, lastOut;
   logic [ADDR_W-1:0] dinAddr, wgtAddr, outAddr;

   assign cfgZero = (bus.cfg_grp_i == '0) | (bus.cfg_co_i == '0) | (bus.cfg_pix_i == '0);
   assign issueRd = (stateReg == ISSUE);

   mac_loop_cnt #(
      .GRP_W (GRP_W),
      .CO_W  (CO_W),
      .PIX_W (PIX_W),
      .ADDR_W(ADDR_W)
   ) loopCnt (
      .clk     (clk),
      .rstn    (rstn),
      .load    (load),
      .cfgGrp  (bus.cfg_grp_i),
      .cfgCo   (bus.cfg_co_i),
      .cfgPix  (bus.cfg_pix_i),
      .stepGrp (stepGrp),
      .stepOut (stepOut),
      .grpFirst(grpFirst),
      .grpLast (grpLast),
      .lastOut (lastOut),
      .dinAddr (dinAddr),
      .wgtAddr (wgtAddr),
      .outAddr (outAddr)
   );

   always_comb begin
      stateNext = stateReg;
      load      = 1'b0;
      stepGrp   = 1'b0;
      stepOut   = 1'b0;
      case (stateReg)
         IDLE: begin
            if (bus.start_i) begin
               load      = 1'b1;
               stateNext = cfgZero ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            stepGrp = 1'b1;
            if (grpLast) stateNext = DRAIN;
         end
         // Drain counts the mac_last cycle itself, so WRITE lands PIPE_LAT+1 cycles later.
         DRAIN: begin
            if (drainCntReg == DR_W'(PIPE_LAT)) stateNext = WRITE;
         end
         WRITE: begin
            if (bus.out_rdy_i) begin
               stepOut   = 1'b1;
               stateNext = lastOut ? FIN : ISSUE;
            end
         end
         FIN:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stateReg    <= IDLE;
         drainCntReg <= '0;
         macVldReg   <= 1'b0;
         macFirstReg <= 1'b0;
         macLastReg  <= 1'b0;
         doneReg     <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         drainCntReg <= (stateReg == DRAIN) ? drainCntReg + 1'b1 : '0;
         macVldReg   <= issueRd;
         macFirstReg <= issueRd & grpFirst;
         macLastReg  <= issueRd & grpLast;
         doneReg     <= (stateReg == FIN);
      end
   end

   assign bus.busy_o      = (stateReg != IDLE);
   assign bus.done_o      = doneReg;
   assign bus.din_rd_o    = issueRd;
   assign bus.wgt_rd_o    = issueRd;
   assign bus.din_addr_o  = dinAddr;
   assign bus.wgt_addr_o  = wgtAddr;
   assign bus.mac_vld_o   = macVldReg;
   assign bus.mac_first_o = macFirstReg;
   assign bus.mac_last_o  = macLastReg;
   assign bus.out_vld_o   = (stateReg == WRITE);
   assign bus.out_addr_o  = outAddr;

endmodule

// File: tb/tb_mac_bank_seq.sv
// Scoreboard bench for mac_bank_seq: a loop-nest model queues expected reads, MAC beats,
// writes and done pulses; a negedge monitor pops and compares as the DUT produces them.
module tb_mac_bank_seq;

   localparam int PIPE_LAT = 4;
   localparam int GRP_W    = 6;
   localparam int CO_W     = 8;
   localparam int PIX_W    = 12;
   localparam int ADDR_W   = 16;

   typedef struct {
      logic [ADDR_W-1:0] din;
      logic [ADDR_W-1:0] wgt;
   } rd_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mac_bank_seq_if #(.GRP_W(GRP_W), .CO_W(CO_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

   mac_bank_seq #(
      .PIPE_LAT(PIPE_LAT), .GRP_W(GRP_W), .CO_W(CO_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rd_t               rdQ[$];
   logic [1:0]        macQ[$];
   logic [ADDR_W-1:0] wrQ[$];
   int                doneQ[$];

   int startCyc, firstRdCyc, firstMacCyc, firstOutCyc, doneCyc, lastMacLastCyc;
   int wrCount = 0;
   int doneCount = 0;
   int rdyMode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s: DUT produced an event with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Reference: plain pix/co/grp loop nest, addresses by multiplication.
   task automatic expectPass(input int g, input int c, input int p);
      if (g != 0 && c != 0 && p != 0) begin
         for (int pi = 0; pi < p; pi++) begin
            for (int ci = 0; ci < c; ci++) begin
               for (int k = 0; k < g; k++) begin
                  rdQ.push_back('{din: ADDR_W'(pi * g + k), wgt: ADDR_W'(ci * g + k)});
                  macQ.push_back({(k == 0), (k == g - 1)});
               end
               wrQ.push_back(ADDR_W'(pi * c + ci));
            end
         end
      end
      doneQ.push_back(1);
   endtask

   // Monitor / scoreboard
   logic              prevRd = 1'b0, prevOutVld = 1'b0, prevRdy = 1'b0;
   logic [ADDR_W-1:0] prevOutAddr = '0;
   always @(negedge clk) begin
      rd_t        r;
      logic [1:0] m;
      if (!rstn) begin
         rdQ.delete();
         macQ.delete();
         wrQ.delete();
         doneQ.delete();
         prevRd     = 1'b0;
         prevOutVld = 1'b0;
         prevRdy    = 1'b0;
      end else begin
         if (bus.din_rd_o || bus.wgt_rd_o) chk("wgt_rd_eq_din_rd", bus.wgt_rd_o, bus.din_rd_o);
         if (bus.mac_vld_o || prevRd) chk("mac_vld_delay", bus.mac_vld_o, prevRd);
         if (!bus.mac_vld_o && (bus.mac_first_o || bus.mac_last_o))
            chk("mac_flags_without_vld", {bus.mac_first_o, bus.mac_last_o}, 0);
         if (bus.din_rd_o) begin
            if (firstRdCyc < 0) firstRdCyc = cyc;
            if (rdQ.size() == 0) unexpected("rd");
            else begin
               r = rdQ.pop_front();
               chk("din_addr", bus.din_addr_o, r.din);
               chk("wgt_addr", bus.wgt_addr_o, r.wgt);
            end
         end
         if (bus.mac_vld_o) begin
            if (firstMacCyc < 0) firstMacCyc = cyc;
            if (bus.mac_last_o) lastMacLastCyc = cyc;
            if (macQ.size() == 0) unexpected("mac_vld");
            else begin
               m = macQ.pop_front();
               chk("mac_first_last", {bus.mac_first_o, bus.mac_last_o}, m);
            end
         end
         if (bus.out_vld_o && !prevOutVld) begin
            if (firstOutCyc < 0) firstOutCyc = cyc;
            chk("out_vld_latency", cyc - lastMacLastCyc, PIPE_LAT + 1);
         end
         if (prevOutVld && !prevRdy) begin
            chk("out_vld_hold", bus.out_vld_o, 1);
            chk("out_addr_hold", bus.out_addr_o, prevOutAddr);
         end
         if (bus.out_vld_o && bus.out_rdy_i) begin
            wrCount++;
            if (wrQ.size() == 0) unexpected("write");
            else chk("out_addr", bus.out_addr_o, wrQ.pop_front());
         end
         if (bus.done_o) begin
            doneCyc = cyc;
            doneCount++;
            chk("busy_low_at_done", bus.busy_o, 0);
            if (doneQ.size() == 0) unexpected("done");
            else void'(doneQ.pop_front());
         end
         prevRd      = bus.din_rd_o;
         prevOutVld  = bus.out_vld_o;
         prevRdy     = bus.out_rdy_i;
         prevOutAddr = bus.out_addr_o;
      end
   end

   // out_rdy driver: 0 = always ready, 1 = random, 2 = held low
   initial begin
      bus.out_rdy_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdyMode)
            0:       bus.out_rdy_i = 1'b1;
            1:       bus.out_rdy_i = 1'($urandom_range(0, 1));
            default: bus.out_rdy_i = 1'b0;
         endcase
      end
   end

   int passDone0;
   int passWr0;

   task automatic startPass(input int g, input int c, input int p);
      expectPass(g, c, p);
      @(posedge clk);
      #1;
      bus.cfg_grp_i = GRP_W'(g);
      bus.cfg_co_i  = CO_W'(c);
      bus.cfg_pix_i = PIX_W'(p);
      bus.start_i   = 1'b1;
      startCyc      = cyc;
      firstRdCyc    = -1;
      firstMacCyc   = -1;
      firstOutCyc   = -1;
      doneCyc       = -1;
      passDone0     = doneCount;
      passWr0       = wrCount;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int k = 0;
      while (doneCount == passDone0 && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (doneCount == passDone0) begin
         failures++;
         $display("FAIL %s_timeout: got no done_o within %0d cycles", name, budget);
      end
      @(posedge clk);
      #1;
      chk({name, "_rd_left"}, rdQ.size(), 0);
      chk({name, "_wr_left"}, wrQ.size(), 0);
   endtask

   task automatic checkResetOutputs(input string name);
      chk(name, {bus.busy_o, bus.done_o, bus.din_rd_o, bus.wgt_rd_o, bus.mac_vld_o,
                 bus.mac_first_o, bus.mac_last_o, bus.out_vld_o, bus.din_addr_o,
                 bus.wgt_addr_o, bus.out_addr_o}, 0);
   endtask

   initial begin
      int k;
      bus.start_i   = 1'b0;
      bus.cfg_grp_i = '0;
      bus.cfg_co_i  = '0;
      bus.cfg_pix_i = '0;
      #2;
      checkResetOutputs("reset_outputs");
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      // 1: single output, exact cycle timing
      startPass(1, 1, 1);
      waitDone("t1", 100);
      chk("t1_rd_cycle", firstRdCyc - startCyc, 1);
      chk("t1_mac_cycle", firstMacCyc - startCyc, 2);
      chk("t1_out_cycle", firstOutCyc - startCyc, 7);
      chk("t1_done_cycle", doneCyc - startCyc, 9);

      // 2: address sequences and throughput with out_rdy held high
      startPass(3, 2, 2);
      waitDone("t2", 200);
      chk("t2_done_cycle", doneCyc - startCyc, 4 * (3 + PIPE_LAT + 2) + 2);
      chk("t2_writes", wrCount - passWr0, 4);

      // 3: back-pressure in WRITE
      rdyMode = 2;
      startPass(2, 1, 1);
      k = 0;
      while (!bus.out_vld_o && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t3_out_vld_seen", bus.out_vld_o, 1);
      for (int i = 0; i < 10; i++) begin
         chk("t3_stall_vld", bus.out_vld_o, 1);
         chk("t3_stall_addr", bus.out_addr_o, 0);
         chk("t3_stall_no_rd_mac", {bus.din_rd_o, bus.mac_vld_o}, 0);
         @(posedge clk);
         #1;
      end
      rdyMode = 0;
      waitDone("t3", 100);

      // 4: zero filter count goes straight to FIN
      startPass(2, 0, 3);
      waitDone("t4", 50);
      chk("t4_done_cycle", doneCyc - startCyc, 2);
      chk("t4_no_rd_or_out", {firstRdCyc, firstOutCyc}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});

      // 5: start and cfg changes while busy are ignored
      startPass(3, 2, 2);
      repeat (5) @(posedge clk);
      #1;
      bus.cfg_grp_i = 6'd5;
      bus.cfg_co_i  = 8'd7;
      bus.cfg_pix_i = 12'd9;
      bus.start_i   = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      waitDone("t5", 200);
      chk("t5_done_cycle", doneCyc - startCyc, 4 * (3 + PIPE_LAT + 2) + 2);
      chk("t5_writes", wrCount - passWr0, 4);

      // 6: asynchronous reset during DRAIN, then a clean pass
      startPass(3, 2, 2);
      k = 0;
      while (!bus.mac_last_o && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t6_mac_last_seen", bus.mac_last_o, 1);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      checkResetOutputs("t6_async_reset_outputs");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      startPass(2, 1, 2);
      waitDone("t6", 100);
      chk("t6_writes", wrCount - passWr0, 2);

      // Random configurations with random back-pressure
      rdyMode = 1;
      for (int i = 0; i < 8; i++) begin
         int g, c, p;
         g = int'($urandom_range(1, 5));
         c = int'($urandom_range(1, 3));
         p = int'($urandom_range(1, 3));
         $display("random pass %0d: grp=%0d co=%0d pix=%0d", i, g, c, p);
         startPass(g, c, p);
         waitDone("rnd", 3000);
         chk("rnd_writes", wrCount - passWr0, c * p);
      end
      rdyMode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
